base3_to_base2: RTL and testbench

Converts a packed base-3 number (16 ternary digits, 2 bits per digit) back to 16-bit binary, using one Horner step (acc·3 + digit) per clock. It sits directly downstream of the base-2→base-3 converter and consumes its `base3_no`/`done` output pair, closing the conversion loop for round-trip checking. It also flags invalid digit codes and binary overflow.

---
 rtl/base3_to_base2_pkg.sv | 20 ++
 rtl/base3_to_base2_if.sv | 28 ++
 rtl/base3_to_base2_mul3_add.sv | 21 ++
 rtl/base3_to_base2.sv | 102 ++++++++++
 tb/tb_base3_to_base2.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/base3_to_base2_pkg.sv
// Shared definitions for the base-3 to base-2 converter: sizes, FSM state
// encoding and ternary digit codes.
package base3_pkg;

  localparam int DIGITS = 16;
  localparam int OUT_W  = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] DIG_0   = 2'b00;
  localparam logic [1:0] DIG_1   = 2'b01;
  localparam logic [1:0] DIG_2   = 2'b10;
  localparam logic [1:0] INVALID = 2'b11;

endpackage

// File: rtl/base3_to_base2_if.sv
// Start/result bundle between the upstream base-2->base-3 stage and this
// converter.
//
// Handshake: en is a start request that is only looked at while the
// converter is IDLE; base3_no must be valid in that same cycle. There is no
// back-pressure: done is a one-cycle valid pulse, and base2_no/err/ovf stay
// stable from that pulse until the next done.
interface base3_to_base2_if;
  import base3_pkg::*;

  logic                  en;
  logic [2*DIGITS-1:0]   base3_no;
  logic [OUT_W-1:0]      base2_no;
  logic                  done;
  logic                  err;
  logic                  ovf;

  modport master (
    output en, base3_no,
    input  base2_no, done, err, ovf
  );

  modport slave (
    input  en, base3_no,
    output base2_no, done, err, ovf
  );

endinterface

// File: rtl/base3_to_base2_mul3_add.sv
// One Horner step: nxt = acc*3 + d, built from a shift and two adds.
// An invalid digit code is flagged and contributes 0.
module mul3_add
  import base3_pkg::*;
(
  input  logic [OUT_W-1:0] acc,
  input  logic [1:0]       d,
  output logic [OUT_W+1:0] nxt,
  output logic             bad
);

  logic [OUT_W+1:0] acc_ext;
  logic [1:0]       d_val;

  assign acc_ext = {2'b00, acc};
  assign bad     = (d == INVALID);
  assign d_val   = bad ? DIG_0 : d;
  // Two guard bits hold the carry out of the 16-bit accumulator.
  assign nxt     = (acc_ext << 1) + acc_ext + {{OUT_W{1'b0}}, d_val};

endmodule

// File: rtl/base3_to_base2.sv
// Packed ternary (16 digits, 2 bits each, MSD first) to 16-bit binary.
// One Horner step per clock over a fixed 16 cycles, with sticky flags for
// invalid digit codes and for results that do not fit in 16 bits.
module base3_to_base2
  import base3_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  base3_to_base2_if.slave         bus,
  output state_e                  state_dbg
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  state_e               state_q, state_d;
  logic [2*DIGITS-1:0]  sh_q;
  logic [OUT_W-1:0]     acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 err_r, ovf_r;
  logic [OUT_W-1:0]     base2_q;
  logic                 done_q, err_q, ovf_q;

  logic [OUT_W+1:0]     nxt;
  logic                 bad;
  logic                 nxt_ovf;
  logic                 conv_last;

  // Most significant unprocessed digit is always at the top of sh_q.
  mul3_add u_mul3_add (
    .acc (acc_q),
    .d   (sh_q[2*DIGITS-1 -: 2]),
    .nxt (nxt),
    .bad (bad)
  );

  assign nxt_ovf   = |nxt[OUT_W+1:OUT_W];
  assign conv_last = (state_q == CONV) && (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: IDLE waits for en, CONV runs a fixed 16 steps, DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.en) state_d = CONV;
      CONV:    if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Working registers: capture on start, one Horner step per CONV cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      err_r <= 1'b0;
      ovf_r <= 1'b0;
    end else if (state_q == IDLE && bus.en) begin
      sh_q  <= bus.base3_no;
      acc_q <= '0;
      cnt_q <= '0;
      err_r <= 1'b0;
      ovf_r <= 1'b0;
    end else if (state_q == CONV) begin
      sh_q  <= sh_q << 2;
      acc_q <= nxt[OUT_W-1:0];
      cnt_q <= cnt_q + 1'b1;
      err_r <= err_r | bad;
      ovf_r <= ovf_r | nxt_ovf;
    end
  end

  // Result registers: loaded on the last step (folding in that step) and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base2_q <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= conv_last;
      if (conv_last) begin
        base2_q <= nxt[OUT_W-1:0];
        err_q   <= err_r | bad;
        ovf_q   <= ovf_r | nxt_ovf;
      end
    end
  end

  assign bus.base2_no = base2_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.ovf      = ovf_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_base3_to_base2.sv
// Directed bench for base3_to_base2: hand-computed vectors, reset abort,
// back-to-back operation and a round trip through a ternary encoder model.
module tb_base3_to_base2;
  import base3_pkg::*;

  logic   clk;
  logic   rst_n;
  state_e state_dbg;
  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  logic [OUT_W-1:0] exp_q[$];

  base3_to_base2_if bus();

  base3_to_base2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Upstream base-2 -> base-3 stage model.
  function automatic logic [31:0] to_base3(input logic [15:0] v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[2*i +: 2] = 2'(x % 3);
      x = x / 3;
    end
    return r;
  endfunction

  // One conversion from IDLE: checks latency, results, done pulse width.
  task automatic convert(input string tag, input logic [31:0] b3,
                         input logic [15:0] exp_b2, input logic exp_err,
                         input logic exp_ovf);
    int lat;
    bus.base3_no = b3;
    bus.en       = 1'b1;
    @(posedge clk); #1;
    bus.en       = 1'b0;
    bus.base3_no = $urandom;
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "/latency"}, lat, 16);
    check_eq({tag, "/base2_no"}, bus.base2_no, exp_b2);
    check_eq({tag, "/err"}, bus.err, exp_err);
    check_eq({tag, "/ovf"}, bus.ovf, exp_ovf);
    @(posedge clk); #1;
    check_eq({tag, "/done_width"}, bus.done, 0);
    check_eq({tag, "/idle"}, state_dbg, IDLE);
  endtask

  initial begin
    logic [15:0] rt_vals[6];
    logic [15:0] bb_vals[4];
    int          ndone;
    int          last_done;
    int          waited;

    rt_vals = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd255, 16'd65535};
    bb_vals = '{16'd7, 16'd1000, 16'd65535, 16'd12345};

    // Reset.
    bus.en       = 1'b0;
    bus.base3_no = '0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst/base2_no", bus.base2_no, 0);
    check_eq("rst/done", bus.done, 0);
    check_eq("rst/err", bus.err, 0);
    check_eq("rst/ovf", bus.ovf, 0);
    check_eq("rst/state", state_dbg, IDLE);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    convert("zero",  32'h0000_0000, 16'd0,     1'b0, 1'b0);
    convert("t101",  32'h0000_0011, 16'd10,    1'b0, 1'b0);
    convert("max",   32'h0010_AA08, 16'hFFFF,  1'b0, 1'b0);
    convert("ovf",   32'h0020_0000, 16'd52562, 1'b0, 1'b1);
    convert("ovf_clear", 32'h0000_0011, 16'd10, 1'b0, 1'b0);
    convert("bad0",  32'h0000_0003, 16'd0,     1'b1, 1'b0);
    convert("bad1",  32'h0000_0007, 16'd3,     1'b1, 1'b0);

    // Reset mid-conversion, with non-zero outputs held beforehand.
    convert("pre_rst", 32'h0020_0000, 16'd52562, 1'b0, 1'b1);
    bus.base3_no = 32'h0010_AA08;
    bus.en       = 1'b1;
    @(posedge clk); #1;
    bus.en = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    check_eq("midrst/in_conv", state_dbg, CONV);
    rst_n = 1'b0;
    #1;
    check_eq("midrst/base2_no", bus.base2_no, 0);
    check_eq("midrst/done", bus.done, 0);
    check_eq("midrst/err", bus.err, 0);
    check_eq("midrst/ovf", bus.ovf, 0);
    check_eq("midrst/state", state_dbg, IDLE);
    @(negedge clk) rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    check_eq("midrst/no_done", ndone, 0);

    // Back-to-back with en held high; base3_no scrambled outside IDLE.
    bus.base3_no = to_base3(bb_vals[0]);
    exp_q.push_back(bb_vals[0]);
    bus.en = 1'b1;
    @(posedge clk); #1;
    bus.base3_no = $urandom;
    last_done = 0;
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      while (!bus.done && waited < 40) begin
        @(posedge clk); #1;
        waited++;
      end
      check_eq("b2b/seen_done", bus.done, 1);
      if (k > 0) check_eq("b2b/period", cyc - last_done, 18);
      last_done = cyc;
      if (exp_q.size() > 0) check_eq("b2b/base2_no", bus.base2_no, exp_q.pop_front());
      else                  check_eq("b2b/queue_empty", 1, 0);
      check_eq("b2b/err", bus.err, 0);
      if (k == 3) bus.en = 1'b0;
      @(posedge clk); #1;
      if (k < 3) begin
        bus.base3_no = to_base3(bb_vals[k+1]);
        exp_q.push_back(bb_vals[k+1]);
        @(posedge clk); #1;
        bus.base3_no = $urandom;
      end
    end
    check_eq("b2b/drained", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("b2b/stopped", state_dbg, IDLE);

    // Round trip through the encoder model.
    foreach (rt_vals[i])
      convert($sformatf("rt%0d", rt_vals[i]), to_base3(rt_vals[i]), rt_vals[i], 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
